// File: rtl/state_shift_sequencer.sv
// ============================================================================
// Module     : state_shift_sequencer
// Description: Drives the serial shift controls of the 5x64-bit ASCON state
//              register so that each pass rotates every word once.
//              Optional macro STATE_SHIFT_ABORT_EN adds an abort_i input.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module state_shift_sequencer #(
    parameter int WORD_SIZE = 64,
    parameter int PAR       = 5,
    parameter int D         = 1,
    parameter int RND_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cmd_type_i,
    input  logic [RND_W-1:0] rounds_i,
    input  logic             load_i,
    input  logic             hold_i,
`ifdef STATE_SHIFT_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             ready_o,
    output logic             write_en_o,
    output logic             shift_en_o,
    output logic             shift_type_o,
    output logic             last_cycle_o,
    output logic             pass_done_o,
    output logic             done_o
);

    localparam int SPD      = (D + 1) * PAR;
    localparam int N1       = (WORD_SIZE + PAR - 1) / PAR;
    localparam int ND       = (WORD_SIZE + SPD - 1) / SPD;
    localparam int NMAX_ALL = (N1 > ND) ? N1 : ND;
    localparam int CNT_W    = $clog2(NMAX_ALL + 1);

    localparam logic [CNT_W-1:0] C_LAST_UNM = CNT_W'(N1 - 1);
    localparam logic [CNT_W-1:0] C_LAST_MSK = CNT_W'(ND - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   slice_q;
    logic [RND_W-1:0]   pass_q;
    logic [RND_W-1:0]   rounds_q;
    logic               type_q;
    logic               write_en_q;
    logic               shift_en_q;
    logic               last_q;
    logic               done_q;

    logic               w_abort;
    logic [CNT_W-1:0]   w_last_idx;
    logic               w_first_is_last;
    logic [CNT_W-1:0]   w_slice_d;
    logic [RND_W-1:0]   w_pass_inc;
    logic [RND_W-1:0]   w_pass_d;
    logic               w_job_end;

`ifdef STATE_SHIFT_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    // Outputs are registered one cycle ahead, so hold_i sampled at an edge
    // gates the shift of the cycle that follows it.
    always_comb begin
        w_last_idx      = type_q ? C_LAST_UNM : C_LAST_MSK;
        w_first_is_last = ((cmd_type_i ? C_LAST_UNM : C_LAST_MSK) == '0);
        w_pass_inc      = pass_q + RND_W'(1);
        w_slice_d       = slice_q;
        w_pass_d        = pass_q;
        if (shift_en_q) begin
            if (last_q) begin
                w_slice_d = '0;
                w_pass_d  = w_pass_inc;
            end else begin
                w_slice_d = slice_q + CNT_W'(1);
            end
        end
        w_job_end = shift_en_q && last_q && (w_pass_inc == rounds_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slice_q    <= '0;
            pass_q     <= '0;
            rounds_q   <= '0;
            type_q     <= 1'b1;
            write_en_q <= 1'b0;
            shift_en_q <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            write_en_q <= 1'b0;
            shift_en_q <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_i) begin
                        state_q    <= ST_LOAD;
                        write_en_q <= 1'b1;
                    end else if (start_i) begin
                        type_q   <= cmd_type_i;
                        rounds_q <= rounds_i;
                        slice_q  <= '0;
                        pass_q   <= '0;
                        if (rounds_i == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_SHIFT;
                            shift_en_q <= !hold_i;
                            last_q     <= !hold_i && w_first_is_last;
                        end
                    end
                end
                ST_LOAD: state_q <= ST_IDLE;
                ST_SHIFT: begin
                    if (w_abort || w_job_end) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        slice_q    <= w_slice_d;
                        pass_q     <= w_pass_d;
                        shift_en_q <= !hold_i;
                        last_q     <= !hold_i && (w_slice_d == w_last_idx);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready_o      = (state_q == ST_IDLE);
    assign write_en_o   = write_en_q;
    assign shift_en_o   = shift_en_q;
    assign shift_type_o = type_q;
    assign last_cycle_o = last_q;
    assign pass_done_o  = last_q;
    assign done_o       = done_q;

endmodule

`default_nettype wire
